// File: rtl/fft_frame_builder.sv
// Collects saturated 16.8 samples into a 16-deep fill buffer and hands complete
// frames to a downstream FFT, dropping frames (sticky overrun) while one is in flight.
module fft_frame_builder #(
    parameter int CLAMP_HI = 511,
    parameter int CLAMP_LO = -512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [15:0] sample_in,
    input  logic               fft_done,
    output logic [23:0]        t0,
    output logic [23:0]        t1,
    output logic [23:0]        t2,
    output logic [23:0]        t3,
    output logic [23:0]        t4,
    output logic [23:0]        t5,
    output logic [23:0]        t6,
    output logic [23:0]        t7,
    output logic [23:0]        t8,
    output logic [23:0]        t9,
    output logic [23:0]        t10,
    output logic [23:0]        t11,
    output logic [23:0]        t12,
    output logic [23:0]        t13,
    output logic [23:0]        t14,
    output logic [23:0]        t15,
    output logic               new_t,
    output logic               busy,
    output logic               overrun,
    output logic [3:0]         fill_count
);

    localparam logic [0:0] READY = 1'b0;
    localparam logic [0:0] BUSY  = 1'b1;

    localparam logic signed [15:0] HI16 = 16'(CLAMP_HI);
    localparam logic signed [15:0] LO16 = 16'(CLAMP_LO);

    logic [0:0]         state_q, state_d;
    logic [3:0]         fillCount_q, fillCount_d;
    logic               newT_q, newT_d;
    logic               overrun_q, overrun_d;
    logic [23:0]        fillBuf_q [16];
    logic [23:0]        tReg_q [16];

    logic signed [15:0] clamped;
    logic [23:0]        formatted;
    logic               frameDone;
    logic               doneAccept;
    logic               issue;

    always_comb begin
        clamped = sample_in;
        if (sample_in > HI16) begin
            clamped = HI16;
        end else if (sample_in < LO16) begin
            clamped = LO16;
        end
    end

    assign formatted = {clamped, 8'h00};

    // A done seen while new_t is still high belongs to the previous frame.
    always_comb begin
        frameDone   = sample_valid && (fillCount_q == 4'd15);
        doneAccept  = (state_q == BUSY) && fft_done && !newT_q;
        issue       = frameDone && ((state_q == READY) || doneAccept);

        state_d = state_q;
        if (issue) begin
            state_d = BUSY;
        end else if (doneAccept) begin
            state_d = READY;
        end

        fillCount_d = sample_valid ? fillCount_q + 4'd1 : fillCount_q;
        newT_d      = issue;
        overrun_d   = overrun_q | (frameDone && !issue);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= READY;
            fillCount_q <= 4'd0;
            newT_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                fillBuf_q[i] <= 24'h0;
                tReg_q[i]    <= 24'h0;
            end
        end else begin
            state_q     <= state_d;
            fillCount_q <= fillCount_d;
            newT_q      <= newT_d;
            overrun_q   <= overrun_d;
            if (sample_valid) begin
                fillBuf_q[fillCount_q] <= formatted;
            end
            // The 16th sample bypasses the buffer so the frame is out with latency 1.
            if (issue) begin
                for (int i = 0; i < 15; i++) begin
                    tReg_q[i] <= fillBuf_q[i];
                end
                tReg_q[15] <= formatted;
            end
        end
    end

    assign t0  = tReg_q[0];
    assign t1  = tReg_q[1];
    assign t2  = tReg_q[2];
    assign t3  = tReg_q[3];
    assign t4  = tReg_q[4];
    assign t5  = tReg_q[5];
    assign t6  = tReg_q[6];
    assign t7  = tReg_q[7];
    assign t8  = tReg_q[8];
    assign t9  = tReg_q[9];
    assign t10 = tReg_q[10];
    assign t11 = tReg_q[11];
    assign t12 = tReg_q[12];
    assign t13 = tReg_q[13];
    assign t14 = tReg_q[14];
    assign t15 = tReg_q[15];

    assign new_t      = newT_q;
    assign busy       = state_q;
    assign overrun    = overrun_q;
    assign fill_count = fillCount_q;

endmodule

// File: doc/fft_frame_builder.md
FFT_FRAME_BUILDER -- requirements
Module: fft_frame_builder

Interface
REQ-001 SHALL have parameter CLAMP_HI, default 511, meaning the upper saturation bound of the integer sample.
REQ-002 SHALL have parameter CLAMP_LO, default -512, meaning the lower saturation bound of the integer sample.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-006 SHALL have port sample_in  input  16  signed two's-complement audio sample.
REQ-007 SHALL have port fft_done  input  1  the downstream FFT processor has finished the frame in flight.
REQ-008 SHALL have ports t0..t15  output  24 each  frame samples in 16.8 signed fixed point; t0 is the oldest sample.
REQ-009 SHALL have port new_t  output  1  one-cycle frame-valid strobe to the FFT processor.
REQ-010 SHALL have port busy  output  1  a frame is in flight and fft_done has not yet been accepted.
REQ-011 SHALL have port overrun  output  1  sticky flag: at least one completed frame was dropped.
REQ-012 SHALL have port fill_count  output  4  number of samples held in the fill buffer.

Function
REQ-013 SHALL saturate each accepted sample: above CLAMP_HI becomes CLAMP_HI; below CLAMP_LO becomes CLAMP_LO.
REQ-014 SHALL format each clamped sample as {16-bit signed integer, 8'h00}; for example, 511 gives 24'h01FF00 and -512 gives 24'hFE0000.
REQ-015 SHALL write the formatted sample into fill slot fill_count and increment fill_count on every cycle with sample_valid=1, in all states, including while busy.
REQ-016 SHALL consider a frame complete on the edge where fill_count=15 and sample_valid=1, and SHALL wrap fill_count to 0 on that edge.
REQ-017 SHALL use two states: READY (busy=0) and BUSY (busy=1).
REQ-018 On a frame complete in READY, SHALL load t0..t15 from the fill buffer on that edge; the 16th sample goes to t15.
REQ-019 On the same edge, SHALL set new_t=1 for exactly one cycle and SHALL transition to BUSY.
REQ-020 SHALL make the new frame appear on t0..t15 in the cycle after the 16th sample is accepted, with latency 1.
REQ-021 SHALL hold t0..t15 stable from the new_t cycle until the next frame issue.
REQ-022 In BUSY, SHALL ignore fft_done during the cycle in which new_t=1, because a stale done from the previous frame must not release the frame.
REQ-023 In BUSY, SHALL transition to READY on the first subsequent rising edge where fft_done=1.
REQ-024 If a frame completes in BUSY on an edge where fft_done=1 and new_t=0, SHALL issue the frame as in READY, i.e. accept fft_done and issue simultaneously; new_t pulses and the state stays BUSY.
REQ-025 If a frame completes in BUSY without a qualifying fft_done, SHALL drop the frame, keep t0..t15 unchanged, set overrun=1 and stay in BUSY.
REQ-026 SHALL never assert new_t on two consecutive cycles.
REQ-027 SHALL clear overrun only by reset.

Reset
REQ-028 SHALL apply all of the following while reset=0 at a rising edge: fill_count=0, t0..t15=0, new_t=0, busy=0, overrun=0, state READY.
REQ-029 SHALL discard a partial fill or an in-flight frame when reset is applied mid-operation, and SHALL not emit new_t for it.
REQ-030 SHALL accept a sample presented with sample_valid=1 on the first edge after reset deasserts.

Verification
REQ-031 Basic frame: 16 valid samples 0..15 with fft_done=0 -> new_t one cycle after the 16th, t0=24'h000000, t15=24'h000F00, busy=1, fill_count=0.
REQ-032 Saturation: samples 1000, -1000, 511, -512 -> t values 24'h01FF00, 24'hFE0000, 24'h01FF00, 24'hFE0000.
REQ-033 Done handling: fft_done held at 1 through the new_t cycle -> busy stays 1 during new_t, then clears on the next edge; fft_done=0 the whole time -> busy stays 1.
REQ-034 Overrun: 32 consecutive samples with fft_done=0 -> one new_t, second frame dropped, t0..t15 still hold frame 1, overrun=1; a later fft_done pulse -> busy=0, overrun still 1.
REQ-035 Simultaneous event: 16th sample of frame 2 on the same edge as fft_done=1 -> new_t pulses, t loads frame 2, busy stays 1, overrun=0.
REQ-036 Mid-operation reset: reset=0 after 9 samples -> fill_count=0, all outputs 0; 16 further samples -> one new_t carrying only the post-reset samples.
